button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Input-side front end for the truco scoreboard. It takes the two raw, asynchronous, bouncing player pushbuttons and produces the clean single-cycle point-request pulses Ba/Bb that the scoreboard top consumes. It performs synchronization, per-button debounce, press-edge detection, simultaneous-press arbitration and game-over gating. It sits between the board pins and the scoreboard's Ba/Bb inputs.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (min 2).
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a press or a release (min 2).
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted), released synchronously by the board logic.
raw_a  input  1  player A pushbutton, active-high, asynchronous, may bounce.
raw_b  input  1  player B pushbutton, active-high, asynchronous, may bounce.
enable  input  1  1 = pulses allowed; tied to the inverse of fim_jogo.
Ba  output  1  one-cycle pulse: accepted press of A.
Bb  output  1  one-cycle pulse: accepted press of B.
stable_a  output  1  debounced level of A.
stable_b  output  1  debounced level of B.
conflict  output  1  one-cycle pulse: A and B accepted in the same cycle.

Behaviour:
- Reset (reset=0, asynchronous): all synchronizer stages, counters and FSMs are cleared. Ba=Bb=conflict=0, stable_a=stable_b=0, FSMs go to IDLE. Reset mid-debounce discards the partial count. After release, a button already held must be fully re-debounced, and it then yields exactly one pulse.
- Synchronizer: SYNC_STAGES flops per button. s_x is the last stage.
- Per-button FSM (identical for A and B), with counter cnt:
  - IDLE (stable=0): s_x=1 -> CONF_PRESS, cnt=1.
  - CONF_PRESS: s_x=0 -> IDLE, cnt=0 (bounce rejected). s_x=1 with cnt<DEBOUNCE_CYCLES-1 -> cnt+1. s_x=1 with cnt=DEBOUNCE_CYCLES-1 -> PRESSED, and a press event fires for that cycle.
  - PRESSED (stable=1): s_x=0 -> CONF_REL, cnt=1.
  - CONF_REL: s_x=1 -> PRESSED, cnt=0. s_x=0 with cnt=DEBOUNCE_CYCLES-1 -> IDLE, no event.
- stable_x = 1 in PRESSED and CONF_REL, otherwise 0. It is registered.
- Latency: if raw_x rises before edge k and stays high, Ba/Bb is high during the cycle following edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1, for exactly 1 cycle.
- Holding a button produces one pulse only. A new pulse requires an accepted release (return to IDLE) followed by an accepted press.
- Output stage (registered, same cycle as the event):
  - Only A event and enable=1 -> Ba=1.
  - Only B event and enable=1 -> Bb=1.
  - Both events in the same cycle and enable=1 -> Ba=Bb=0, conflict=1. Neither player scores.
  - enable=0 -> Ba=Bb=conflict=0. FSMs and stable_x still track the buttons. Events suppressed while enable=0 are lost, not queued.
- Ba and Bb are never high in the same cycle. conflict is never high together with Ba or Bb.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1. There is no wrap-around.

Test Plan:
(Parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4.)
1. Clean press: reset pulse, then raw_a=1 set before edge 10 and held for 20 cycles -> Ba=1 only in the cycle after edge 15; stable_a rises at the same edge; Bb=conflict=0 throughout.
2. Bounce: raw_b toggles 1,0,1,0 each cycle, then stays 1 -> exactly one Bb pulse, 5 edges after the final rising sample; no pulse during the bounce.
3. Hold/release/re-press: A held 50 cycles -> one Ba. Then release for 6 cycles and press again for 6 cycles -> a second Ba. A release glitch of 2 cycles does not produce a second Ba.
4. Simultaneous press: raw_a and raw_b rise before the same edge -> conflict=1 for 1 cycle, Ba=Bb=0. Offset raw_b by 1 cycle -> Ba, then Bb, in consecutive cycles, with conflict=0.
5. Gating: enable=0 while A is accepted -> no Ba, but stable_a=1. Setting enable=1 while A is still held -> no late Ba.
6. Reset mid-operation: assert reset=0 asynchronously (between edges) during CONF_PRESS with cnt=2 -> all outputs 0 immediately. After release with raw_a still 1 -> Ba after the full 2+4 edge latency, and only once.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Input front end for the truco scoreboard. It turns the two raw, bouncing
// player pushbuttons into clean one-cycle point-request pulses (Ba/Bb).
//
// Each button passes through an N-stage synchronizer and then a small
// debounce FSM. A press is accepted only after DEBOUNCE_CYCLES consecutive
// high samples, and a release only after DEBOUNCE_CYCLES consecutive low
// samples. The FSM raises a press event on the cycle that accepts a press.
// The output stage turns those events into Ba/Bb. If both presses are
// accepted in the same cycle it raises conflict, so that neither player
// scores. While enable is low, no pulse is produced.
//
// Parameters:
//   SYNC_STAGES      flip-flop stages per input synchronizer (>= 2)
//   DEBOUNCE_CYCLES  stable samples needed to accept a press/release (>= 2)
//   CNT_W            debounce counter width (derived)
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   raw_a     player A pushbutton, active-high, asynchronous
//   raw_b     player B pushbutton, active-high, asynchronous
//   enable    1 = pulses allowed (inverse of game over)
//   Ba        one-cycle pulse, accepted press of A
//   Bb        one-cycle pulse, accepted press of B
//   stable_a  debounced level of A
//   stable_b  debounced level of B
//   conflict  one-cycle pulse, A and B accepted in the same cycle
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  input  logic enable,
  output logic Ba,
  output logic Bb,
  output logic stable_a,
  output logic stable_b,
  output logic conflict
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONF_PRESS = 2'd1,
    PRESSED    = 2'd2,
    CONF_REL   = 2'd3
  } state_t;

  // Last count value before a press or release is accepted. The counter
  // saturates here and never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0] w_raw;
  logic [1:0] w_press;
  logic [1:0] w_stable;

  logic r_ba;
  logic r_bb;
  logic r_conflict;

  assign w_raw = {raw_b, raw_a};

  // ---------------------------------------------------------------------------
  // Per-button synchronizer + debounce FSM (index 0 = A, index 1 = B)
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   r_stable;
    logic                   w_stable_next;
    logic                   w_press_evt;

    // Shift register synchronizer; the oldest stage feeds the FSM.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else begin
        r_state  <= w_state_next;
        r_cnt    <= w_cnt_next;
        r_stable <= w_stable_next;
      end
    end

    // Next-state logic. The sample that leaves IDLE/PRESSED counts as the
    // first of the DEBOUNCE_CYCLES samples, so the count starts at 1.
    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_press_evt  = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s) begin
            w_state_next = CONF_PRESS;
            w_cnt_next   = CNT_ONE;
          end
        end
        CONF_PRESS: begin
          if (!w_s) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else if (r_cnt >= CNT_LAST) begin
            w_state_next = PRESSED;
            w_cnt_next   = '0;
            w_press_evt  = 1'b1;
          end else begin
            w_cnt_next   = r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_s) begin
            w_state_next = CONF_REL;
            w_cnt_next   = CNT_ONE;
          end
        end
        CONF_REL: begin
          if (w_s) begin
            w_state_next = PRESSED;
            w_cnt_next   = '0;
          end else if (r_cnt >= CNT_LAST) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end

    // The debounced level is registered from the next state. It therefore
    // changes on the same edge as the FSM and never glitches.
    assign w_stable_next = (w_state_next == PRESSED) || (w_state_next == CONF_REL);

    assign w_press[gi]  = w_press_evt;
    assign w_stable[gi] = r_stable;
  end

  // ---------------------------------------------------------------------------
  // Output stage: arbitration and game-over gating. Events that arrive
  // while enable is low are dropped, not held back.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ba       <= 1'b0;
      r_bb       <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_ba       <= enable &  w_press[0] & ~w_press[1];
      r_bb       <= enable & ~w_press[0] &  w_press[1];
      r_conflict <= enable &  w_press[0] &  w_press[1];
    end
  end

  assign Ba       = r_ba;
  assign Bb       = r_bb;
  assign conflict = r_conflict;
  assign stable_a = w_stable[0];
  assign stable_b = w_stable[1];

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Runs directed scenarios followed by randomized button/enable/reset
// activity. Every cycle the outputs are compared against a reference model.
// The model treats the debounced level as flipping whenever the last
// DEBOUNCE_CYCLES synchronized samples all disagree with it. Each
// synchronized sample is the raw input delayed by SYNC_STAGES edges.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int MAXE = 4096;

  logic clk;
  logic reset;
  logic raw_a;
  logic raw_b;
  logic enable;
  logic Ba;
  logic Bb;
  logic stable_a;
  logic stable_b;
  logic conflict;

  button_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_a   (raw_a),
    .raw_b   (raw_b),
    .enable  (enable),
    .Ba      (Ba),
    .Bb      (Bb),
    .stable_a(stable_a),
    .stable_b(stable_b),
    .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit raw_log [2][MAXE];
  bit m_stable [2];
  int edge_n;
  bit exp_ba, exp_bb, exp_cf;

  // Observation bookkeeping
  int n_checks = 0;
  int n_fail   = 0;
  int ba_cnt, bb_cnt, cf_cnt;
  int ba_edge, bb_edge;

  function automatic bit s_at(input int b, input int i);
    if (i < SYNC) return 1'b0;
    return raw_log[b][i - SYNC];
  endfunction

  function automatic bit window_opposite(input int b, input int e);
    for (int j = 0; j < DEB; j++) begin
      if (e - j < 0) return 1'b0;
      if (s_at(b, e - j) == m_stable[b]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    edge_n      = 0;
    m_stable[0] = 1'b0;
    m_stable[1] = 1'b0;
    exp_ba      = 1'b0;
    exp_bb      = 1'b0;
    exp_cf      = 1'b0;
  endtask

  task automatic model_edge();
    bit ev [2];
    int idx;
    idx = edge_n;
    edge_n++;
    if (idx < MAXE) begin
      raw_log[0][idx] = raw_a;
      raw_log[1][idx] = raw_b;
    end
    for (int b = 0; b < 2; b++) begin
      ev[b] = 1'b0;
      if (idx < MAXE && window_opposite(b, idx)) begin
        m_stable[b] = ~m_stable[b];
        ev[b]       = m_stable[b];
      end
    end
    exp_ba = enable &&  ev[0] && !ev[1];
    exp_bb = enable && !ev[0] &&  ev[1];
    exp_cf = enable &&  ev[0] &&  ev[1];
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("Ba",       int'(Ba),       int'(exp_ba));
    check("Bb",       int'(Bb),       int'(exp_bb));
    check("conflict", int'(conflict), int'(exp_cf));
    check("stable_a", int'(stable_a), int'(m_stable[0]));
    check("stable_b", int'(stable_b), int'(m_stable[1]));
  endtask

  task automatic clear_counts();
    ba_cnt  = 0;
    bb_cnt  = 0;
    cf_cnt  = 0;
    ba_edge = -1;
    bb_edge = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_clear();
    else        model_edge();
    #1;
    check_outputs();
    if (Ba)       begin ba_cnt++; ba_edge = edge_n; end
    if (Bb)       begin bb_cnt++; bb_edge = edge_n; end
    if (conflict) cf_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset between edges, confirm the asynchronous clear, hold it
  // for two edges, then release it away from the clock edge.
  task automatic do_reset(input int dly);
    #(dly);
    reset = 1'b0;
    model_clear();
    #1;
    check_outputs();
    ticks(2);
    reset = 1'b1;
    clear_counts();
  endtask

  task automatic idle_all(input int n);
    raw_a = 1'b0;
    raw_b = 1'b0;
    ticks(n);
    clear_counts();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seg_a, seg_b;
    reset  = 1'b0;
    raw_a  = 1'b0;
    raw_b  = 1'b0;
    enable = 1'b1;
    model_clear();
    clear_counts();
    ticks(2);
    reset = 1'b1;

    // 1. Clean press: raw_a set before edge 10 -> Ba after edge 15 only.
    ticks(9);
    raw_a = 1'b1;
    ticks(20);
    check("t1_ba_count", ba_cnt, 1);
    check("t1_ba_edge",  ba_edge, 15);
    check("t1_bb_count", bb_cnt, 0);
    check("t1_cf_count", cf_cnt, 0);
    idle_all(10);

    // 2. Bounce on B, then steady -> exactly one Bb.
    raw_b = 1'b1; tick();
    raw_b = 1'b0; tick();
    raw_b = 1'b1; tick();
    raw_b = 1'b0; tick();
    check("t2_no_bb_during_bounce", bb_cnt, 0);
    raw_b = 1'b1;
    ticks(12);
    check("t2_bb_count", bb_cnt, 1);
    idle_all(10);

    // 3. Hold 50, release 6, press 6, glitch 2.
    raw_a = 1'b1; ticks(50);
    check("t3_hold_count", ba_cnt, 1);
    raw_a = 1'b0; ticks(6);
    raw_a = 1'b1; ticks(6);
    check("t3_repress_count", ba_cnt, 2);
    ticks(6);
    raw_a = 1'b0; ticks(2);
    raw_a = 1'b1; ticks(12);
    check("t3_glitch_count", ba_cnt, 2);
    idle_all(10);

    // 4. Simultaneous press -> conflict; offset press -> Ba then Bb.
    raw_a = 1'b1; raw_b = 1'b1; ticks(10);
    check("t4_cf_count", cf_cnt, 1);
    check("t4_ba_count", ba_cnt, 0);
    check("t4_bb_count", bb_cnt, 0);
    idle_all(10);
    raw_a = 1'b1; tick();
    raw_b = 1'b1; ticks(10);
    check("t4_off_ba_count", ba_cnt, 1);
    check("t4_off_bb_count", bb_cnt, 1);
    check("t4_off_order",    bb_edge, ba_edge + 1);
    check("t4_off_cf_count", cf_cnt, 0);
    idle_all(10);

    // 5. Gating: press A while disabled, then enable while still held.
    enable = 1'b0;
    raw_a  = 1'b1; ticks(10);
    check("t5_stable_a", int'(stable_a), 1);
    check("t5_ba_gated", ba_cnt, 0);
    enable = 1'b1; ticks(10);
    check("t5_no_late_ba", ba_cnt, 0);
    idle_all(10);

    // 6. Reset mid CONF_PRESS with B already stable high.
    raw_b = 1'b1; ticks(10);
    check("t6_stable_b_before", int'(stable_b), 1);
    raw_a = 1'b1; ticks(4);
    #3;
    reset = 1'b0;
    model_clear();
    #1;
    check_outputs();
    raw_b = 1'b0;
    ticks(2);
    reset = 1'b1;
    clear_counts();
    ticks(14);
    check("t6_ba_count", ba_cnt, 1);
    check("t6_ba_edge",  ba_edge, 6);
    idle_all(10);

    // Randomized button activity with occasional enable flips and resets.
    seg_a = 0;
    seg_b = 0;
    for (int c = 0; c < 900; c++) begin
      if (seg_a == 0) begin
        raw_a = 1'($urandom_range(0, 1));
        seg_a = $urandom_range(1, 10);
      end
      if (seg_b == 0) begin
        raw_b = 1'($urandom_range(0, 1));
        seg_b = $urandom_range(1, 10);
      end
      seg_a--;
      seg_b--;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if (c % 300 == 299) do_reset($urandom_range(1, 3));
      else                tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
